uart_tx: RTL and testbench

// - Transmit serializer downstream of the UART TX data FIFO; pops one byte per frame over valid/ready.
// - Emits start bit, DATA_BITS data bits LSB first, optional parity, then 1 or 2 stop bits on tx_o.
// - Bit period comes from the clock-divider register; frame format comes from the cfg register.
// - tx_en_i comes from the ctrl register.

---
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer.
// Pops one byte per frame from the TX FIFO over valid/ready and shifts out
// start bit, DATA_BITS data bits LSB first, optional parity, and 1 or 2 stop
// bits on tx_o. Bit period and frame format are captured when the byte is
// accepted, so register writes during a frame only affect the next one.
// Build option: define UART_TX_PARITY_EN to include the parity bit support;
// without it the parity inputs are ignored and frames never carry parity.

module uart_tx #(
  parameter int DATA_BITS     = 8,
  parameter int CLK_DIV_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tx_en_i,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div_i,
  input  logic                     parity_en_i,
  input  logic                     parity_odd_i,
  input  logic                     stop2_i,
  input  logic [DATA_BITS-1:0]     data_i,
  input  logic                     data_valid_i,
  output logic                     data_ready_o,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]               state;
  logic [CLK_DIV_WIDTH-1:0] period;       // latched bit period, never 0
  logic [CLK_DIV_WIDTH-1:0] cnt;          // cycles left in current bit, minus one
  logic [DATA_BITS-1:0]     shreg;        // remaining data bits, next bit at [0]
  logic [IDX_W-1:0]         idx;          // index of data bit currently on the line
  logic                     stop2_q;
  logic                     stop_second;  // second stop bit in progress
  logic                     tx_q;
  logic                     done_q;
`ifdef UART_TX_PARITY_EN
  logic                     par_en_q;
  logic                     par_bit_q;
`else
  logic                     unused_parity;
  assign unused_parity = parity_en_i ^ parity_odd_i;
`endif

  logic                     transfer;
  logic                     bit_end;
  logic [CLK_DIV_WIDTH-1:0] div_clamped;

  // A divider of 0 would stall the line forever; treat it as one cycle per bit.
  assign div_clamped  = (clk_div_i == '0) ? CLK_DIV_WIDTH'(1) : clk_div_i;
  assign data_ready_o = (state == IDLE) & tx_en_i & ~rst_i;
  assign transfer     = data_valid_i & data_ready_o;
  assign bit_end      = (cnt == '0);
  assign busy_o       = (state != IDLE);
  assign tx_o         = tx_q;
  assign done_o       = done_q;

  // Frame sequencer: accepts a byte in IDLE, then steps one bit per period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      period      <= '0;
      cnt         <= '0;
      shreg       <= '0;
      idx         <= '0;
      stop2_q     <= 1'b0;
      stop_second <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (transfer) begin
          state       <= START;
          tx_q        <= 1'b0;
          shreg       <= data_i;
          period      <= div_clamped;
          cnt         <= div_clamped - 1'b1;
          stop2_q     <= stop2_i;
          stop_second <= 1'b0;
          idx         <= '0;
`ifdef UART_TX_PARITY_EN
          par_en_q    <= parity_en_i;
          par_bit_q   <= (^data_i) ^ parity_odd_i;
`endif
        end
      end else if (!bit_end) begin
        cnt <= cnt - 1'b1;
      end else begin
        // Current bit has been held for a full period; move to the next one.
        cnt <= period - 1'b1;
        case (state)
          START: begin
            state <= DATA;
            idx   <= '0;
            tx_q  <= shreg[0];
            shreg <= shreg >> 1;
          end
          DATA: begin
            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= PARITY;
                tx_q  <= par_bit_q;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
`else
              state <= STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              idx   <= idx + 1'b1;
              tx_q  <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            tx_q  <= 1'b1;
          end
`endif
          STOP: begin
            if (stop2_q && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state  <= IDLE;
              tx_q   <= 1'b1;
              done_q <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx_q  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a cycle-level frame model.
// The model expands each accepted byte into the expected per-cycle line
// values and checks tx/busy/done/ready every cycle; directed checks pin
// frame lengths and individual bit values by hand.

module tb_uart_tx;

  localparam int DB = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_en = 1'b0;
  logic [CW-1:0] clk_div = 32'd4;
  logic          par_en = 1'b0;
  logic          par_odd = 1'b0;
  logic          stop2 = 1'b0;
  logic [DB-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ready, tx, busy, done;

  uart_tx #(.DATA_BITS(DB), .CLK_DIV_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .clk_div_i(clk_div),
    .parity_en_i(par_en), .parity_odd_i(par_odd), .stop2_i(stop2),
    .data_i(data), .data_valid_i(valid), .data_ready_o(ready),
    .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  int cyc = 0;
  int done_cnt = 0;
  int last_xfer = 0;
  logic samples [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (done === 1'b1) done_cnt++;
  end

  // Frame model: q holds the line value for every remaining cycle of the frame.
  bit q[$];
  bit m_done = 1'b0;
  always @(posedge clk) begin
    int p;
    bit pb;
    if (rst) begin
      q.delete();
      m_done = 1'b0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
      m_done = (q.size() == 0);
    end else begin
      m_done = 1'b0;
      if (valid && tx_en) begin
        p = (clk_div == 0) ? 1 : int'(clk_div);
        for (int k = 0; k < p; k++) q.push_back(1'b0);
        for (int b = 0; b < DB; b++)
          for (int k = 0; k < p; k++) q.push_back(data[b]);
`ifdef UART_TX_PARITY_EN
        if (par_en) begin
          pb = (^data) ^ par_odd;
          for (int k = 0; k < p; k++) q.push_back(pb);
        end
`endif
        for (int k = 0; k < p * (stop2 ? 2 : 1); k++) q.push_back(1'b1);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("model_tx",    {31'd0, tx},    {31'd0, (q.size() != 0) ? q[0] : 1'b1});
      chk("model_busy",  {31'd0, busy},  {31'd0, q.size() != 0});
      chk("model_done",  {31'd0, done},  {31'd0, m_done});
      chk("model_ready", {31'd0, ready}, {31'd0, (q.size() == 0) && tx_en && !rst});
    end
  end

  // Present a byte and wait for the pop; returns just after the transfer edge.
  task automatic send(input logic [7:0] b, input int div, input bit pe, input bit po, input bit s2);
    int n;
    data = b; clk_div = div; par_en = pe; par_odd = po; stop2 = s2;
    valid = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      n++;
    end
    if (n >= 300) begin
      chk("send_timeout", 32'd0, 32'd1);
      valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      last_xfer = cyc;
      valid = 1'b0;
    end
  endtask

  // Count busy cycles and record tx for each; returns on the done cycle.
  task automatic measure(output int len);
    len = 0;
    while (len < 1000) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      samples[len] = tx;
      len++;
    end
    if (len >= 1000) chk("measure_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, t1, d0;
    int exp1 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int exp6 [8]  = '{0, 1, 0, 1, 1, 0, 1, 0};

    // Reset state, with enable high to show ready is gated by reset.
    tx_en = 1'b1;
    valid = 1'b1;
    @(posedge clk); #1 armed = 1'b1;
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; valid = 1'b0;

    // Basic frame 0xA5, P=4.
    d0 = done_cnt;
    send(8'hA5, 4, 0, 0, 0);
    measure(len);
    chk("t1_len", len, 32'd40);
    for (int i = 0; i < 40; i++) chk("t1_bit", {31'd0, samples[i]}, exp1[i / 4]);
    chk("t1_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("t1_done_cnt", done_cnt - d0, 32'd1);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 2, 1, 0, 0);
    measure(len);
    chk("par_even_len", len, 32'd22);
    chk("par_even_bit", {31'd0, samples[18]}, 32'd1);
    chk("par_even_bit2", {31'd0, samples[19]}, 32'd1);
    send(8'h07, 2, 1, 1, 0);
    measure(len);
    chk("par_odd_len", len, 32'd22);
    chk("par_odd_bit", {31'd0, samples[18]}, 32'd0);
`else
    send(8'h07, 2, 1, 0, 0);
    measure(len);
    chk("nopar_len", len, 32'd20);
    chk("nopar_stop", {31'd0, samples[18]}, 32'd1);
`endif

    // Two stop bits with P=3, then clamped divider.
    send(8'h00, 3, 0, 0, 1);
    measure(len);
    chk("stop2_len", len, 32'd33);
    chk("stop2_last_data", {31'd0, samples[26]}, 32'd0);
    for (int i = 27; i < 33; i++) chk("stop2_high", {31'd0, samples[i]}, 32'd1);
    send(8'h55, 0, 0, 0, 0);
    measure(len);
    chk("clamp_len", len, 32'd10);

    // Back-to-back with valid held high.
    @(posedge clk); #1;
    d0 = done_cnt;
    send(8'h00, 1, 0, 0, 0);
    t1 = last_xfer;
    send(8'hFF, 1, 0, 0, 0);
    chk("b2b_gap", last_xfer - t1, 32'd11);
    measure(len);
    chk("b2b_len", len, 32'd10);
    @(posedge clk); #1;
    chk("b2b_done_cnt", done_cnt - d0, 32'd2);

    // Enable low blocks the pop.
    tx_en = 1'b0;
    data = 8'h3C; valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("en_off_ready", {31'd0, ready}, 32'd0);
      chk("en_off_tx", {31'd0, tx}, 32'd1);
    end
    @(posedge clk); #1 valid = 1'b0; tx_en = 1'b1;

    // Enable dropped mid-frame: frame still completes.
    send(8'h3C, 2, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1 tx_en = 1'b0;
    measure(len);
    chk("en_drop_rest", len, 32'd14);
    chk("en_drop_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1 tx_en = 1'b1;

    // Divider change mid-frame has no effect on the current frame.
    send(8'hC3, 2, 0, 0, 0);
    clk_div = 32'd7;
    measure(len);
    chk("div_change_len", len, 32'd20);

    // Reset during DATA aborts the frame.
    send(8'h5A, 4, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    send(8'h5A, 4, 0, 0, 0);
    measure(len);
    chk("post_rst_len", len, 32'd40);
    chk("post_rst_start", {31'd0, samples[0]}, 32'd0);
    for (int i = 0; i < 8; i++) chk("post_rst_bit", {31'd0, samples[4 + 4 * i]}, exp6[i]);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
